// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared defaults and helper function for the FIR output decimator
//
// Purpose: default sample width and decimation factor, plus a constant clog2
// usable in parameter and port-width expressions.
// Optional feature macro used by the decimator: FIR_DEC_AVG_EN.
package fir_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEC_DEF    = 4;

  // Ceiling log2; returns 0 for values of 1 or less.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - single-clock first-word-fall-through FIFO
//
// Purpose: holds decimated samples until the consumer takes them.
// Ports:
//   clk_i, rstn_i     clock, synchronous active-low reset
//   push_i/push_data_i write request and data; accepted when not full, or
//                      when full and a pop happens on the same edge
//   pop_i             read request; ignored while empty
//   pop_data_o        head entry (0 while empty)
//   full_o, empty_o   occupancy flags
//   level_o           number of stored entries
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      push_data_i,
  input  logic                   pop_i,
  output logic [DATA_W-1:0]      pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [clog2(DEPTH):0]  level_o
);

  localparam int PTR_W = clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    level_q, level_d;
  logic              do_push, do_pop;

  assign full_o  = (level_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO can still take a write when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // DEPTH is a power of two, so pointers wrap by plain overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (PTR_W+1)'(1);
      2'b01:   level_d = level_q - (PTR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o    = level_q;

endmodule

// File: rtl/fir_out_decimator.sv
// rtl/fir_out_decimator.sv - decimates a FIR output stream by DEC into an output FIFO
//
// Purpose: counts valid input samples in groups of DEC and pushes one result
// per group into a FWFT FIFO. With FIR_DEC_AVG_EN defined the result is the
// floor average of the group; otherwise it is the last sample of the group.
// Ports:
//   clk_data   clock (rising edge)
//   rst        synchronous active-low reset
//   in_data    signed input sample, in_valid marks a new sample
//   out_data   FIFO head, out_valid = FIFO not empty, out_ready = consumer pop
//   clr_ovf    clears the sticky overflow flag (a same-edge drop wins)
//   overflow   sticky: a decimated sample was dropped on a full FIFO
//   level      FIFO occupancy
module fir_out_decimator
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEC    = DEC_DEF,
  parameter int DEPTH  = 8
) (
  input  logic                  clk_data,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  clr_ovf,
  output logic                  overflow,
  output logic [clog2(DEPTH):0] level
);

  localparam int PH_W = clog2(DEC);

  logic [PH_W-1:0]   phase_q, phase_d;
  logic              overflow_q, overflow_d;
  logic              last_phase, push, pop, drop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] push_data;

  assign last_phase = (phase_q == PH_W'(DEC - 1));
  assign push       = in_valid && last_phase;
  assign pop        = out_ready && !fifo_empty;
  assign drop       = push && fifo_full && !pop;

  always_comb begin
    phase_d    = phase_q;
    overflow_d = overflow_q;
    if (in_valid) phase_d = last_phase ? '0 : phase_q + PH_W'(1);
    if (drop)         overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk_data) begin
    if (!rst) begin
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef FIR_DEC_AVG_EN
  localparam int ACC_W = DATA_W + PH_W;

  // Wide enough for DEC full-scale samples, so the running sum never wraps.
  logic [ACC_W-1:0] acc_q, acc_d, sum;

  assign sum = acc_q + {{PH_W{in_data[DATA_W-1]}}, in_data};

  always_comb begin
    acc_d = acc_q;
    if (in_valid) acc_d = last_phase ? '0 : sum;
  end

  always_ff @(posedge clk_data) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  // Arithmetic shift by log2(DEC) then truncation to DATA_W is exactly the
  // top DATA_W bits of the sum; this rounds toward minus infinity.
  assign push_data = sum[ACC_W-1:PH_W];
`else
  assign push_data = in_data;
`endif

  fir_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i       (clk_data),
    .rstn_i      (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level)
  );

  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule
